// File: rtl/imuldiv_int_div_iterative_pkg.sv
// Shared imuldiv constants: divider FSM states, fn encodings and step count,
// plus the multiplier request message definitions used across the imuldiv unit.
package imuldiv_int_div_iterative_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic FN_DIV  = 1'b0;
  localparam logic FN_DIVU = 1'b1;

  localparam logic [5:0] DIV_STEPS = 6'd32;

  // Multiplier request message layout, kept here so both units share one definition.
  localparam logic [2:0] MUL_FN_MUL    = 3'd0;
  localparam logic [2:0] MUL_FN_MULH   = 3'd1;
  localparam logic [2:0] MUL_FN_MULHSU = 3'd2;
  localparam logic [2:0] MUL_FN_MULHU  = 3'd3;

  typedef struct packed {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
  } mulreq_msg_t;

endpackage

// File: rtl/imuldiv_int_div_iterative_dpath.sv
// Restoring-division datapath: captures magnitudes and sign flags on load,
// performs one shift/subtract step per cycle while step is high.
module imuldiv_int_div_iterative_dpath
  import imuldiv_int_div_iterative_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        fn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic [64:0] remquot;
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [31:0] divisor;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic        is_signed;
  logic        quot_neg;
  logic        rem_neg;

  always_comb begin
    is_signed = (fn == FN_DIV);
    a_mag     = (is_signed && a[31]) ? (~a + 32'd1) : a;
    b_mag     = (is_signed && b[31]) ? (~b + 32'd1) : b;
    shifted   = remquot << 1;
    // The partial remainder never exceeds twice the divisor, so bit 32 of the
    // difference is a reliable "did not fit" flag.
    diff      = shifted[64:32] - {1'b0, divisor};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remquot  <= '0;
      divisor  <= '0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
    end else if (load) begin
      remquot  <= {33'd0, a_mag};
      divisor  <= b_mag;
      // A zero divisor suppresses the quotient fix so it stays all ones.
      quot_neg <= is_signed && (a[31] ^ b[31]) && (b != 32'd0);
      rem_neg  <= is_signed && a[31];
    end else if (step) begin
      if (diff[32])
        remquot <= shifted;
      else
        remquot <= {diff, shifted[31:0] | 32'd1};
    end
  end

  always_comb begin
    quot_raw = remquot[31:0];
    rem_raw  = remquot[63:32];
    result   = {(rem_neg  ? (~rem_raw  + 32'd1) : rem_raw),
                (quot_neg ? (~quot_raw + 32'd1) : quot_raw)};
  end

endmodule

// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit signed/unsigned divider with val/rdy request and response
// handshakes; a three-state control FSM sequences the restoring datapath.
module imuldiv_int_div_iterative
  import imuldiv_int_div_iterative_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        divreq_msg_fn,
  input  logic [31:0] divreq_msg_a,
  input  logic [31:0] divreq_msg_b,
  input  logic        divreq_val,
  output logic        divreq_rdy,
  output logic [63:0] divresp_msg_result,
  output logic        divresp_val,
  input  logic        divresp_rdy
);

  div_state_t state;
  logic [5:0] count;
  logic       load;
  logic       step;

  assign load = (state == IDLE) && divreq_val;
  assign step = (state == CALC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      divreq_rdy  <= 1'b1;
      divresp_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (divreq_val) begin
            state      <= CALC;
            count      <= DIV_STEPS;
            divreq_rdy <= 1'b0;
          end
        end
        CALC: begin
          count <= count - 6'd1;
          if (count == 6'd1) begin
            state       <= DONE;
            divresp_val <= 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE here means the handshake edge itself never accepts.
          if (divresp_rdy) begin
            state       <= IDLE;
            divresp_val <= 1'b0;
            divreq_rdy  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          count       <= '0;
          divreq_rdy  <= 1'b1;
          divresp_val <= 1'b0;
        end
      endcase
    end
  end

  imuldiv_int_div_iterative_dpath u_dpath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .fn     (divreq_msg_fn),
    .a      (divreq_msg_a),
    .b      (divreq_msg_b),
    .result (divresp_msg_result)
  );

endmodule

// File: tb/tb_imuldiv_int_div_iterative.sv
// Scoreboard bench for the iterative divider: expected results are queued at
// accept and compared when the response handshake happens.
module tb_imuldiv_int_div_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;

  logic [63:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imuldiv_int_div_iterative dut (
    .clk                (clk),
    .reset              (reset),
    .divreq_msg_fn      (divreq_msg_fn),
    .divreq_msg_a       (divreq_msg_a),
    .divreq_msg_b       (divreq_msg_b),
    .divreq_val         (divreq_val),
    .divreq_rdy         (divreq_rdy),
    .divresp_msg_result (divresp_msg_result),
    .divresp_val        (divresp_val),
    .divresp_rdy        (divresp_rdy)
  );

  function automatic logic [63:0] model(input logic fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (fn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  // Presents a request and returns at the negedge after the accept edge.
  task automatic send_req(input logic fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expected);
    int guard;
    guard = 0;
    @(negedge clk);
    divreq_msg_fn = fn;
    divreq_msg_a  = a;
    divreq_msg_b  = b;
    divreq_val    = 1'b1;
    while (divreq_rdy !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (divreq_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL accept_wait: divreq_rdy=%b required 1", divreq_rdy);
    end
    @(posedge clk);
    exp_q.push_back(expected);
    @(negedge clk);
    divreq_val = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (divresp_val !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_resp(input string name, input int lat);
    logic [63:0] expected;
    tests_run++;
    if (lat != 32) begin
      tests_failed++;
      $display("[TB] FAIL %s_latency: got %0d cycles required 32", name, lat);
    end
    expected = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    tests_run++;
    if (divresp_msg_result !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s_result: got %h required %h", name, divresp_msg_result, expected);
    end
    divresp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    divresp_rdy = 1'b0;
    tests_run++;
    if (divresp_val !== 1'b0 || divreq_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s_release: val=%b rdy=%b required val=0 rdy=1", name, divresp_val, divreq_rdy);
    end
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (divreq_rdy !== 1'b1 || divresp_val !== 1'b0 || divresp_msg_result !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: rdy=%b val=%b result=%h required 1 0 0",
               divreq_rdy, divresp_val, divresp_msg_result);
    end
    divreq_msg_fn = 1'b1;
    divreq_msg_a  = 32'd9;
    divreq_msg_b  = 32'd3;
    divreq_val    = 1'b1;
    reset         = 1'b1;
    @(posedge clk);
    exp_q.push_back({32'd0, 32'd3});
    @(negedge clk);
    divreq_val = 1'b0;
    tests_run++;
    if (divreq_rdy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_accept: rdy=%b required 0", divreq_rdy);
    end
    wait_resp(lat);
    take_resp("post_reset", lat);
  endtask

  task automatic test_signed();
    int lat;
    send_req(1'b0, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    wait_resp(lat);
    take_resp("signed_neg7_div2", lat);
  endtask

  task automatic test_unsigned();
    int lat;
    send_req(1'b1, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC});
    wait_resp(lat);
    take_resp("unsigned_div2", lat);
  endtask

  task automatic test_div_by_zero();
    int lat;
    send_req(1'b0, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    wait_resp(lat);
    take_resp("signed_div0", lat);
    send_req(1'b1, 32'd10, 32'd0, {32'h0000_000A, 32'hFFFF_FFFF});
    wait_resp(lat);
    take_resp("unsigned_div0", lat);
  endtask

  task automatic test_overflow();
    int lat;
    send_req(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    wait_resp(lat);
    take_resp("signed_overflow", lat);
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] a;
    logic [31:0] b;
    logic        fn;
    for (int i = 0; i < 8; i++) begin
      a  = $urandom;
      b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 50));
      if (i % 3 == 0) b = ~b + 32'd1;
      fn = i[0] ^ i[1];
      send_req(fn, a, b, model(fn, a, b));
      wait_resp(lat);
      take_resp("random", lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] held;
    bit ok;
    send_req(1'b0, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    wait_resp(lat);
    held = divresp_msg_result;
    tests_run++;
    if (lat != 32) begin
      tests_failed++;
      $display("[TB] FAIL stall_latency: got %0d cycles required 32", lat);
    end
    divreq_msg_fn = 1'b1;
    divreq_msg_a  = 32'd1000;
    divreq_msg_b  = 32'd9;
    divreq_val    = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (divresp_msg_result !== held || divreq_rdy !== 1'b0 || divresp_val !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold: result=%h rdy=%b val=%b required stable, 0, 1",
               divresp_msg_result, divreq_rdy, divresp_val);
    end
    tests_run++;
    if (divresp_msg_result !== exp_q[0]) begin
      tests_failed++;
      $display("[TB] FAIL stall_result: got %h required %h", divresp_msg_result, exp_q[0]);
    end
    void'(exp_q.pop_front());
    divresp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    divresp_rdy = 1'b0;
    tests_run++;
    if (divreq_rdy !== 1'b1 || divresp_val !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL handshake_no_accept: rdy=%b val=%b required 1 0", divreq_rdy, divresp_val);
    end
    @(posedge clk);
    exp_q.push_back({32'd1, 32'd111});
    @(negedge clk);
    divreq_val = 1'b0;
    tests_run++;
    if (divreq_rdy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL next_accept: rdy=%b required 0", divreq_rdy);
    end
    wait_resp(lat);
    take_resp("back_to_back", lat);
  endtask

  task automatic test_reset_abort();
    int lat;
    bit spurious;
    send_req(1'b1, 32'd12345, 32'd17, model(1'b1, 32'd12345, 32'd17));
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    void'(exp_q.pop_back());
    #1;
    tests_run++;
    if (divreq_rdy !== 1'b1 || divresp_val !== 1'b0 || divresp_msg_result !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_state: rdy=%b val=%b result=%h required 1 0 0",
               divreq_rdy, divresp_val, divresp_msg_result);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (divresp_val !== 1'b0 || divreq_rdy !== 1'b1) spurious = 1'b1;
    end
    tests_run++;
    if (spurious) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_response: val=%b rdy=%b required 0 1", divresp_val, divreq_rdy);
    end
    send_req(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    wait_resp(lat);
    take_resp("after_abort", lat);
  endtask

  initial begin
    reset         = 1'b0;
    divreq_msg_fn = 1'b0;
    divreq_msg_a  = '0;
    divreq_msg_b  = '0;
    divreq_val    = 1'b0;
    divresp_rdy   = 1'b0;
    test_reset();
    test_signed();
    test_unsigned();
    test_div_by_zero();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/imuldiv_int_div_iterative.md
IMULDIV_INT_DIV_ITERATIVE -- requirements
Module: imuldiv_int_div_iterative

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset, asserted when 0.
REQ-004 divreq_msg_fn  input  1  0 = signed div/rem, 1 = unsigned divu/remu.
REQ-005 divreq_msg_a  input  32  dividend.
REQ-006 divreq_msg_b  input  32  divisor.
REQ-007 divreq_val  input  1  request valid.
REQ-008 divreq_rdy  output  1  request ready.
REQ-009 divresp_msg_result  output  64  {remainder[63:32], quotient[31:0]}.
REQ-010 divresp_val  output  1  response valid.
REQ-011 divresp_rdy  input  1  response ready.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 divreq_rdy SHALL be 1 only in IDLE, and divresp_val SHALL be 1 only in DONE.
REQ-014 A request SHALL be accepted on a rising edge in IDLE with divreq_val=1; operands and fn are captured, the counter is loaded with 32, and the state goes to CALC.
REQ-015 In signed mode the operands SHALL be converted to magnitudes at capture; the quotient sign (a[31]^b[31]) and the remainder sign (a[31]) SHALL be registered.
REQ-016 Each CALC edge SHALL perform one restoring step on a 65-bit {rem, quot} register: shift left 1; if the upper part is at least the divisor, subtract it and set the quotient LSB to 1.
REQ-017 After the 32nd CALC step the state SHALL go to DONE, with divresp_val first high exactly 32 cycles after the accept edge.
REQ-018 In DONE, divresp_msg_result SHALL hold stable, with the sign fix already applied, until the divresp_val and divresp_rdy handshake edge, after which the state goes to IDLE.
REQ-019 A new request SHALL NOT be accepted on the response-handshake edge; the earliest next accept is the following edge.
REQ-020 If the divisor is 0, the quotient SHALL be 0xFFFFFFFF and the remainder SHALL equal the original dividend, in both modes, with no sign fix applied.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0.
REQ-022 divreq_val while not in IDLE SHALL be ignored, and divresp_rdy outside DONE SHALL have no effect.
REQ-023 Outputs SHALL depend only on state and registers, with no combinational path from inputs to outputs.

Reset
REQ-024 While reset=0, the state SHALL be IDLE, the counter 0, the datapath registers 0, divresp_val=0 and divreq_rdy=1, regardless of clk.
REQ-025 Asserting reset in CALC or DONE SHALL abort the operation, and no response SHALL be produced for it.
REQ-026 After reset deassertion, the first accept SHALL be possible on the next rising edge.

Structure
REQ-027 The state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2), the fn encodings and the step count 32 SHALL live in the shared imuldiv constants include file, together with the multiplier's message definitions.
REQ-028 The datapath SHALL be one sub-module, imuldiv_int_div_iterative_dpath, driven by control signals from the top-level FSM.
REQ-029 The RTL SHALL be 120-400 lines, with a single 32-bit subtractor and no `/` or `%` operators.

Verification
REQ-030 Bench scenario: signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, with divresp_val rising 32 cycles after accept.
REQ-031 Bench scenario: unsigned 0xFFFFFFF9 / 2 -> quotient 0x7FFFFFFC, remainder 0x00000001.
REQ-032 Bench scenario: divide by zero, signed -5 / 0 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFFB; unsigned 10 / 0 -> quotient 0xFFFFFFFF, remainder 0x0000000A.
REQ-033 Bench scenario: signed 0x80000000 / -1 -> quotient 0x80000000, remainder 0.
REQ-034 Bench scenario: hold divresp_rdy=0 for 5 cycles in DONE -> result stable and divreq_rdy=0 throughout; a second request presented on the handshake edge is accepted one edge later.
REQ-035 Bench scenario: assert reset at CALC step 10 -> immediate IDLE with divresp_val=0; a following 100 / 7 -> quotient 14, remainder 2.
